alu_serial_responder: RTL and testbench

Slice-serial 32-bit ALU that sits on the responder side of the ALU command interface. It accepts one {command, operandA, operandB} request through a valid/ready handshake and evaluates it SLICE bits per clock, carrying the carry across slices. It then presents result, carryout, zero and overflow through a valid/ready response port. It supports the same eight 3-bit commands as the combinational ALU and uses a fraction of its area.

---
 rtl/alu_serial_responder.sv | 176 +++++++++++++++++
 tb/tb_alu_serial_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_responder.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_responder
// Description : Slice-serial ALU on the responder side of a valid/ready
//               command interface; evaluates SLICE bits per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_responder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_command_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_carryout_o,
    output logic             rsp_zero_o,
    output logic             rsp_overflow_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

    localparam logic [2:0] C_CMD_ADD  = 3'b000;
    localparam logic [2:0] C_CMD_SUB  = 3'b001;
    localparam logic [2:0] C_CMD_XOR  = 3'b010;
    localparam logic [2:0] C_CMD_SLT  = 3'b011;
    localparam logic [2:0] C_CMD_AND  = 3'b100;
    localparam logic [2:0] C_CMD_NAND = 3'b101;
    localparam logic [2:0] C_CMD_NOR  = 3'b110;
    localparam logic [2:0] C_CMD_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       cmd_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carryout_q;
    logic             rsp_zero_q;
    logic             rsp_overflow_q;

    logic [SLICE-1:0] w_a_s;
    logic [SLICE-1:0] w_b_s;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_res_s;
    logic             w_cin_msb;
    logic             w_ovf;
    logic             w_is_addsub;
    logic             w_inv_b;
    logic [WIDTH-1:0] w_full;
    logic [WIDTH-1:0] w_final;

    // Operands shift right each RUN cycle, so the active slice is always the low bits.
    always_comb begin
        w_a_s       = a_q[SLICE-1:0];
        w_b_s       = b_q[SLICE-1:0];
        w_sum       = {1'b0, w_a_s} + {1'b0, w_b_s} + {{SLICE{1'b0}}, carry_q};
        w_cin_msb   = w_a_s[SLICE-1] ^ w_b_s[SLICE-1] ^ w_sum[SLICE-1];
        w_ovf       = w_cin_msb ^ w_sum[SLICE];
        w_is_addsub = (cmd_q == C_CMD_ADD) || (cmd_q == C_CMD_SUB);
        w_inv_b     = (req_command_i == C_CMD_SUB) || (req_command_i == C_CMD_SLT);
        case (cmd_q)
            C_CMD_XOR:  w_res_s = w_a_s ^ w_b_s;
            C_CMD_AND:  w_res_s = w_a_s & w_b_s;
            C_CMD_NAND: w_res_s = ~(w_a_s & w_b_s);
            C_CMD_NOR:  w_res_s = ~(w_a_s | w_b_s);
            C_CMD_OR:   w_res_s = w_a_s | w_b_s;
            default:    w_res_s = w_sum[SLICE-1:0];
        endcase
    end

    // Completed slices accumulate from the top down; the newest slice lands in the MSBs.
    generate
        if (SLICE < WIDTH) begin : g_multi_slice
            logic [WIDTH-SLICE-1:0] acc_q;

            assign w_full = {w_res_s, acc_q};

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (state_q == S_RUN) begin
                    acc_q <= w_full[WIDTH-1:SLICE];
                end
            end
        end else begin : g_single_slice
            assign w_full = w_res_s;
        end
    endgenerate

    always_comb begin
        w_final = w_full;
        if (cmd_q == C_CMD_SLT) begin
            w_final    = '0;
            w_final[0] = w_sum[SLICE-1] ^ w_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cmd_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            carry_q        <= 1'b0;
            cnt_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_carryout_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        cmd_q   <= req_command_i;
                        a_q     <= req_a_i;
                        b_q     <= w_inv_b ? ~req_b_i : req_b_i;
                        carry_q <= w_inv_b;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    carry_q <= w_sum[SLICE];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_q        <= S_DONE;
                        rsp_valid_q    <= 1'b1;
                        rsp_result_q   <= w_final;
                        rsp_zero_q     <= (w_final == '0);
                        rsp_carryout_q <= w_is_addsub & w_sum[SLICE];
                        rsp_overflow_q <= w_is_addsub & w_ovf;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o    = rst_n && (state_q == S_IDLE);
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_carryout_o = rsp_carryout_q;
    assign rsp_zero_o     = rsp_zero_q;
    assign rsp_overflow_o = rsp_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_responder
// Description : Self-checking bench for alu_serial_responder at SLICE 8/1/32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_command;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic        req_ready    [3];
    logic        rsp_valid    [3];
    logic [31:0] rsp_result   [3];
    logic        rsp_carryout [3];
    logic        rsp_zero     [3];
    logic        rsp_overflow [3];

    int nvec;
    int nfail;

    typedef struct {
        logic [31:0] r;
        logic        co;
        logic        z;
        logic        ov;
    } exp_t;

    alu_serial_responder #(.WIDTH(32), .SLICE(8)) u_dut_s8 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_command_i(req_command),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result[0]),
        .rsp_carryout_o(rsp_carryout[0]), .rsp_zero_o(rsp_zero[0]), .rsp_overflow_o(rsp_overflow[0])
    );

    alu_serial_responder #(.WIDTH(32), .SLICE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_command_i(req_command),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result[1]),
        .rsp_carryout_o(rsp_carryout[1]), .rsp_zero_o(rsp_zero[1]), .rsp_overflow_o(rsp_overflow[1])
    );

    alu_serial_responder #(.WIDTH(32), .SLICE(32)) u_dut_s32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready[2]), .req_command_i(req_command),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result[2]),
        .rsp_carryout_o(rsp_carryout[2]), .rsp_zero_o(rsp_zero[2]), .rsp_overflow_o(rsp_overflow[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_lat(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 32 : 1);
    endfunction

    // Reference: whole-word arithmetic, signed compare for SLT.
    function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] t;
        e.co = 1'b0;
        e.ov = 1'b0;
        case (cmd)
            3'd0: begin
                t    = {1'b0, a} + {1'b0, b};
                e.r  = t[31:0];
                e.co = t[32];
                e.ov = (a[31] == b[31]) && (e.r[31] != a[31]);
            end
            3'd1: begin
                t    = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.r  = t[31:0];
                e.co = t[32];
                e.ov = (a[31] != b[31]) && (e.r[31] != a[31]);
            end
            3'd2: e.r = a ^ b;
            3'd3: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: e.r = a & b;
            3'd5: e.r = ~(a & b);
            3'd6: e.r = ~(a | b);
            default: e.r = a | b;
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic check(input string tag, input int dut, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, dut, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input int i, input exp_t e);
        check({tag, ".result"}, i, rsp_result[i], e.r);
        check({tag, ".carryout"}, i, {31'd0, rsp_carryout[i]}, {31'd0, e.co});
        check({tag, ".zero"}, i, {31'd0, rsp_zero[i]}, {31'd0, e.z});
        check({tag, ".overflow"}, i, {31'd0, rsp_overflow[i]}, {31'd0, e.ov});
    endtask

    // Entered and left at #1 after a rising edge with every instance idle.
    task automatic run_op(input string tag, input logic [2:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        exp_t e;
        bit   seen [3];
        e = model(cmd, a, b);
        for (int i = 0; i < 3; i++) begin
            check({tag, ".req_ready"}, i, {31'd0, req_ready[i]}, 32'd1);
            seen[i] = 1'b0;
        end
        req_command = cmd;
        req_a       = a;
        req_b       = b;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && rsp_valid[i]) begin
                    seen[i] = 1'b1;
                    check({tag, ".latency"}, i, cyc, exp_lat(i));
                    check_rsp(tag, i, e);
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int i = 0; i < 3; i++) begin
            check({tag, ".rsp_valid_seen"}, i, {31'd0, seen[i]}, 32'd1);
        end
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                req_valid   = ~req_valid;
                req_command = 3'($urandom_range(0, 7));
                req_a       = $urandom;
                req_b       = $urandom;
                @(posedge clk);
                #1;
                for (int i = 0; i < 3; i++) begin
                    check({tag, ".hold_valid"}, i, {31'd0, rsp_valid[i]}, 32'd1);
                    check({tag, ".hold_ready"}, i, {31'd0, req_ready[i]}, 32'd0);
                    check_rsp({tag, ".hold"}, i, e);
                end
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, ".post_valid"}, i, {31'd0, rsp_valid[i]}, 32'd0);
            check({tag, ".post_ready"}, i, {31'd0, req_ready[i]}, 32'd1);
            check({tag, ".idle_result"}, i, rsp_result[i], e.r);
        end
    endtask

    initial begin
        logic [2:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        nvec        = 0;
        nfail       = 0;
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        req_command = 3'd0;
        req_a       = 32'd0;
        req_b       = 32'd0;
        rsp_ready   = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset.req_ready", i, {31'd0, req_ready[i]}, 32'd0);
            check("reset.rsp_valid", i, {31'd0, rsp_valid[i]}, 32'd0);
            check_rsp("reset", i, '{r: 32'd0, co: 1'b0, z: 1'b0, ov: 1'b0});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_1_1",    3'd0, 32'h0000_0001, 32'h0000_0001, 1'b0);
        run_op("sub_1_1",    3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0);
        run_op("sub_0_1",    3'd1, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("add_ovf",    3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("add_wrap",   3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("slt_neg",    3'd3, 32'h8000_0000, 32'h0000_0001, 1'b0);
        run_op("slt_eq",     3'd3, 32'h0000_0001, 32'h0000_0001, 1'b0);
        run_op("slt_ovf",    3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("xor",        3'd2, 32'h0000_000F, 32'h0000_0005, 1'b0);
        run_op("and",        3'd4, 32'h0000_000F, 32'h0000_0005, 1'b0);
        run_op("nand",       3'd5, 32'h0000_000F, 32'h0000_0005, 1'b0);
        run_op("nor",        3'd6, 32'h0000_000F, 32'h0000_0005, 1'b0);
        run_op("or_hold",    3'd7, 32'h0000_000F, 32'h0000_0005, 1'b1);

        for (int n = 0; n < 30; n++) begin
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op("random", rc, ra, rb, 1'b0);
        end

        run_op("pre_reset", 3'd7, 32'h0000_000F, 32'h0000_0005, 1'b0);
        req_command = 3'd0;
        req_a       = $urandom;
        req_b       = $urandom;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("abort.req_ready", i, {31'd0, req_ready[i]}, 32'd0);
            check("abort.rsp_valid", i, {31'd0, rsp_valid[i]}, 32'd0);
            check_rsp("abort", i, '{r: 32'd0, co: 1'b0, z: 1'b0, ov: 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 3; i++) begin
                check("abort.no_partial", i, {31'd0, rsp_valid[i]}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        run_op("add_2_3", 3'd0, 32'd2, 32'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
